// File: rtl/sm83_mcycle_seq.sv
// SM83 M-cycle sequencer: walks each decoded op through its per-M-cycle step table
// and emits zero-latency control strobes; the final FETCH step overlaps the next opcode fetch.
package sm83_mcycle_seq_pkg;
    typedef enum logic [3:0] {
        CTL_NOP        = 4'd0,
        CTL_LD_R8_D8   = 4'd1,
        CTL_LD_R8_HL   = 4'd2,
        CTL_LD_HL_R8   = 4'd3,
        CTL_LD_R16_D16 = 4'd4,
        CTL_JP_D16     = 4'd5,
        CTL_JR_CC_E8   = 4'd6
    } ctl_op_t;

    typedef enum logic [1:0] {
        ADDR_NONE = 2'd0,
        ADDR_PC   = 2'd1,
        ADDR_HL   = 2'd2
    } addr_sel_t;
endpackage

module sm83_mcycle_seq
    import sm83_mcycle_seq_pkg::*;
#(
    parameter int MAX_MCYCLES = 6,
    parameter int IDX_W       = $clog2(MAX_MCYCLES),
    parameter bit COND_JR_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  ctl_op_t          ctl_op,
    input  logic             cond_true,
    input  logic             mem_wait,
    output addr_sel_t        addr_sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             inc_pc,
    output logic             fetch_cycle,
    output logic             mem_to_r8,
    output logic             z_ld,
    output logic             w_ld,
    output logic             pc_ld_wz,
    output logic             pc_add_z,
    output logic             r16_ld_wz,
    output logic [IDX_W-1:0] mcycle,
    output logic             op_done,
    output logic             illegal_op
);

    if (MAX_MCYCLES < 4) begin : g_bad_depth
        $error("sm83_mcycle_seq: MAX_MCYCLES must be at least 4");
    end

    typedef enum logic [2:0] {
        K_FETCH, K_IMM_R8, K_IMM_Z, K_IMM_W, K_HL_R8, K_R8_HL, K_INT_JP, K_INT_JR
    } step_kind_t;

    localparam logic [IDX_W-1:0] STEP0   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] STEP1   = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] STEP2   = IDX_W'(32'd2);
    localparam logic [IDX_W-1:0] STEP3   = IDX_W'(32'd3);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_MCYCLES - 1);

    logic [IDX_W-1:0] mcycle_r;
    ctl_op_t          op_r;
    logic             jr_taken_r;
    logic             boot_r;

    ctl_op_t          op_s;
    logic             illegal_s;
    step_kind_t       kind_s;
    logic             last_s;
    logic             adv_s;

    // Step table lookup; any index outside an op's sequence decodes as FETCH.
    function automatic step_kind_t step_kind(input ctl_op_t op, input logic [IDX_W-1:0] idx,
                                             input logic taken);
        step_kind_t k;
        k = K_FETCH;
        if (idx <= MAX_IDX) begin
            case (op)
                CTL_LD_R8_D8:   k = (idx == STEP0) ? K_IMM_R8 : K_FETCH;
                CTL_LD_R8_HL:   k = (idx == STEP0) ? K_HL_R8  : K_FETCH;
                CTL_LD_HL_R8:   k = (idx == STEP0) ? K_R8_HL  : K_FETCH;
                CTL_LD_R16_D16: k = (idx == STEP0) ? K_IMM_Z  :
                                    (idx == STEP1) ? K_IMM_W  : K_FETCH;
                CTL_JP_D16:     k = (idx == STEP0) ? K_IMM_Z  :
                                    (idx == STEP1) ? K_IMM_W  :
                                    (idx == STEP2) ? K_INT_JP : K_FETCH;
                CTL_JR_CC_E8:   k = (idx == STEP0) ? K_IMM_Z  :
                                    (idx == STEP1 && taken) ? K_INT_JR : K_FETCH;
                default:        k = K_FETCH;
            endcase
        end else begin
            k = K_FETCH;
        end
        return k;
    endfunction

    // Op selection: live ctl_op at step 0 (sanitised), latched op afterwards.
    always_comb begin
        op_s      = op_r;
        illegal_s = 1'b0;
        if (mcycle_r == STEP0) begin
            if (boot_r) begin
                op_s = CTL_NOP;
            end else begin
                case (ctl_op)
                    CTL_NOP, CTL_LD_R8_D8, CTL_LD_R8_HL, CTL_LD_HL_R8,
                    CTL_LD_R16_D16, CTL_JP_D16: op_s = ctl_op;
                    CTL_JR_CC_E8: begin
                        if (COND_JR_EN) begin
                            op_s = ctl_op;
                        end else begin
                            op_s      = CTL_NOP;
                            illegal_s = 1'b1;
                        end
                    end
                    default: begin
                        op_s      = CTL_NOP;
                        illegal_s = 1'b1;
                    end
                endcase
            end
        end else begin
            op_s = op_r;
        end
        kind_s = step_kind(op_s, mcycle_r, jr_taken_r);
        last_s = (kind_s == K_FETCH);
        adv_s  = ~mem_wait;
    end

    // Strobe decode; side-effect strobes are gated while memory stalls.
    always_comb begin
        addr_sel    = ADDR_NONE;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        inc_pc      = 1'b0;
        fetch_cycle = 1'b0;
        mem_to_r8   = 1'b0;
        z_ld        = 1'b0;
        w_ld        = 1'b0;
        pc_ld_wz    = 1'b0;
        pc_add_z    = 1'b0;
        r16_ld_wz   = 1'b0;
        op_done     = 1'b0;
        illegal_op  = 1'b0;
        mcycle      = STEP0;
        if (rst_n) begin
            mcycle     = mcycle_r;
            illegal_op = illegal_s & adv_s;
            case (kind_s)
                K_FETCH: begin
                    addr_sel    = ADDR_PC;
                    mem_rd      = 1'b1;
                    inc_pc      = adv_s;
                    fetch_cycle = adv_s;
                    op_done     = adv_s;
                    r16_ld_wz   = adv_s & (op_s == CTL_LD_R16_D16);
                end
                K_IMM_R8: begin
                    addr_sel  = ADDR_PC;
                    mem_rd    = 1'b1;
                    inc_pc    = adv_s;
                    mem_to_r8 = adv_s;
                end
                K_IMM_Z: begin
                    addr_sel = ADDR_PC;
                    mem_rd   = 1'b1;
                    inc_pc   = adv_s;
                    z_ld     = adv_s;
                end
                K_IMM_W: begin
                    addr_sel = ADDR_PC;
                    mem_rd   = 1'b1;
                    inc_pc   = adv_s;
                    w_ld     = adv_s;
                end
                K_HL_R8: begin
                    addr_sel  = ADDR_HL;
                    mem_rd    = 1'b1;
                    mem_to_r8 = adv_s;
                end
                K_R8_HL: begin
                    addr_sel = ADDR_HL;
                    mem_wr   = 1'b1;
                end
                K_INT_JP: pc_ld_wz = adv_s;
                K_INT_JR: pc_add_z = adv_s;
                default:  addr_sel = ADDR_NONE;
            endcase
        end else begin
            mcycle = STEP0;
        end
    end

    // Sequencer state; everything holds while mem_wait is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcycle_r   <= STEP0;
            op_r       <= CTL_NOP;
            jr_taken_r <= 1'b0;
            boot_r     <= 1'b1;
        end else if (adv_s) begin
            mcycle_r <= (last_s || mcycle_r >= MAX_IDX) ? STEP0 : mcycle_r + STEP1;
            boot_r   <= 1'b0;
            if (mcycle_r == STEP0) begin
                op_r <= op_s;
                if (op_s == CTL_JR_CC_E8) begin
                    jr_taken_r <= cond_true;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm83_mcycle_seq.sv
// Directed bench for sm83_mcycle_seq: drives one M-cycle per call and compares
// mcycle plus the packed strobe word against hand-computed values.
module tb_sm83_mcycle_seq;
    import sm83_mcycle_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    ctl_op_t    ctl_op;
    logic       cond_true;
    logic       mem_wait;
    addr_sel_t  addr_sel;
    logic       mem_rd, mem_wr, inc_pc, fetch_cycle, mem_to_r8, z_ld, w_ld;
    logic       pc_ld_wz, pc_add_z, r16_ld_wz, op_done, illegal_op;
    logic [2:0] mcycle;

    int tests_run;
    int tests_failed;

    sm83_mcycle_seq dut (
        .clk(clk), .rst_n(rst_n), .ctl_op(ctl_op), .cond_true(cond_true),
        .mem_wait(mem_wait), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .inc_pc(inc_pc), .fetch_cycle(fetch_cycle), .mem_to_r8(mem_to_r8),
        .z_ld(z_ld), .w_ld(w_ld), .pc_ld_wz(pc_ld_wz), .pc_add_z(pc_add_z),
        .r16_ld_wz(r16_ld_wz), .mcycle(mcycle), .op_done(op_done),
        .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: [13:12] addr_sel, rd, wr, inc_pc, fetch, mem_to_r8, z, w, jp, jr, r16, done, illegal
    localparam logic [13:0] E_ZERO   = 14'b00_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_FETCH  = 14'b01_1_0_1_1_0_0_0_0_0_0_1_0;
    localparam logic [13:0] E_F_R16  = 14'b01_1_0_1_1_0_0_0_0_0_1_1_0;
    localparam logic [13:0] E_F_ILL  = 14'b01_1_0_1_1_0_0_0_0_0_0_1_1;
    localparam logic [13:0] E_IMMR8  = 14'b01_1_0_1_0_1_0_0_0_0_0_0_0;
    localparam logic [13:0] E_IMMZ   = 14'b01_1_0_1_0_0_1_0_0_0_0_0_0;
    localparam logic [13:0] E_IMMW   = 14'b01_1_0_1_0_0_0_1_0_0_0_0_0;
    localparam logic [13:0] E_HLR8   = 14'b10_1_0_0_0_1_0_0_0_0_0_0_0;
    localparam logic [13:0] E_R8HL   = 14'b10_0_1_0_0_0_0_0_0_0_0_0_0;
    localparam logic [13:0] E_JP     = 14'b00_0_0_0_0_0_0_0_1_0_0_0_0;
    localparam logic [13:0] E_JR     = 14'b00_0_0_0_0_0_0_0_0_1_0_0_0;
    localparam logic [13:0] E_STL_PC = 14'b01_1_0_0_0_0_0_0_0_0_0_0_0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One M-cycle: drive inputs after the falling edge, compare before the next rising edge.
    task automatic cyc(input string tag, input logic rst, input ctl_op_t op, input logic cond,
                       input logic wt, input logic [2:0] exp_mc, input logic [13:0] exp_o);
        logic [13:0] obs;
        @(negedge clk);
        rst_n     = rst;
        ctl_op    = op;
        cond_true = cond;
        mem_wait  = wt;
        #1;
        obs = {addr_sel, mem_rd, mem_wr, inc_pc, fetch_cycle, mem_to_r8, z_ld, w_ld,
               pc_ld_wz, pc_add_z, r16_ld_wz, op_done, illegal_op};
        check_val({tag, "_mc"}, {29'd0, mcycle}, {29'd0, exp_mc});
        check_val({tag, "_out"}, {18'd0, obs}, {18'd0, exp_o});
    endtask

    initial begin
        ctl_op_t bad_op;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        ctl_op       = CTL_NOP;
        cond_true    = 1'b0;
        mem_wait     = 1'b0;
        bad_op       = ctl_op_t'(4'hF);

        cyc("rst0", 1'b0, CTL_JP_D16, 1'b0, 1'b0, 3'd0, E_ZERO);
        cyc("rst1", 1'b0, CTL_JP_D16, 1'b0, 1'b0, 3'd0, E_ZERO);
        cyc("boot", 1'b1, CTL_JP_D16, 1'b0, 1'b0, 3'd0, E_FETCH);

        cyc("ld8_s0", 1'b1, CTL_LD_R8_D8, 1'b0, 1'b0, 3'd0, E_IMMR8);
        cyc("ld8_s1", 1'b1, CTL_NOP,      1'b0, 1'b0, 3'd1, E_FETCH);

        cyc("jp_s0",  1'b1, CTL_JP_D16, 1'b0, 1'b0, 3'd0, E_IMMZ);
        cyc("jp_st1", 1'b1, CTL_NOP,    1'b0, 1'b1, 3'd1, E_STL_PC);
        cyc("jp_st2", 1'b1, CTL_NOP,    1'b0, 1'b1, 3'd1, E_STL_PC);
        cyc("jp_st3", 1'b1, CTL_NOP,    1'b0, 1'b1, 3'd1, E_STL_PC);
        cyc("jp_s1",  1'b1, CTL_NOP,    1'b0, 1'b0, 3'd1, E_IMMW);
        cyc("jp_s2",  1'b1, CTL_NOP,    1'b0, 1'b0, 3'd2, E_JP);
        cyc("jp_s3",  1'b1, CTL_NOP,    1'b0, 1'b0, 3'd3, E_FETCH);

        cyc("jrt_s0", 1'b1, CTL_JR_CC_E8, 1'b1, 1'b0, 3'd0, E_IMMZ);
        cyc("jrt_s1", 1'b1, CTL_NOP,      1'b0, 1'b0, 3'd1, E_JR);
        cyc("jrt_s2", 1'b1, CTL_NOP,      1'b0, 1'b0, 3'd2, E_FETCH);
        // Condition high only during the stalled step-0 cycle must not count.
        cyc("jrn_st", 1'b1, CTL_JR_CC_E8, 1'b1, 1'b1, 3'd0, E_STL_PC);
        cyc("jrn_s0", 1'b1, CTL_JR_CC_E8, 1'b0, 1'b0, 3'd0, E_IMMZ);
        cyc("jrn_s1", 1'b1, CTL_NOP,      1'b1, 1'b0, 3'd1, E_FETCH);

        cyc("r16_s0", 1'b1, CTL_LD_R16_D16, 1'b0, 1'b0, 3'd0, E_IMMZ);
        cyc("r16_s1", 1'b1, CTL_NOP,        1'b0, 1'b0, 3'd1, E_IMMW);
        cyc("r16_s2", 1'b1, CTL_NOP,        1'b0, 1'b0, 3'd2, E_F_R16);
        cyc("sthl_0", 1'b1, CTL_LD_HL_R8,   1'b0, 1'b0, 3'd0, E_R8HL);
        cyc("sthl_1", 1'b1, CTL_NOP,        1'b0, 1'b0, 3'd1, E_FETCH);
        cyc("ldhl_0", 1'b1, CTL_LD_R8_HL,   1'b0, 1'b0, 3'd0, E_HLR8);
        cyc("ldhl_1", 1'b1, CTL_NOP,        1'b0, 1'b0, 3'd1, E_FETCH);

        cyc("nop_st", 1'b1, CTL_NOP, 1'b0, 1'b1, 3'd0, E_STL_PC);
        cyc("nop",    1'b1, CTL_NOP, 1'b0, 1'b0, 3'd0, E_FETCH);

        cyc("ill_st", 1'b1, bad_op,  1'b0, 1'b1, 3'd0, E_STL_PC);
        cyc("ill",    1'b1, bad_op,  1'b0, 1'b0, 3'd0, E_F_ILL);
        cyc("ill_nx", 1'b1, CTL_NOP, 1'b0, 1'b0, 3'd0, E_FETCH);

        cyc("jpr_s0", 1'b1, CTL_JP_D16,   1'b0, 1'b0, 3'd0, E_IMMZ);
        cyc("jpr_s1", 1'b1, CTL_NOP,      1'b0, 1'b0, 3'd1, E_IMMW);
        cyc("jpr_rs", 1'b0, CTL_NOP,      1'b0, 1'b0, 3'd0, E_ZERO);
        cyc("jpr_bt", 1'b1, CTL_LD_R8_D8, 1'b0, 1'b0, 3'd0, E_FETCH);
        cyc("jpr_ld", 1'b1, CTL_LD_R8_D8, 1'b0, 1'b0, 3'd0, E_IMMR8);
        cyc("jpr_f",  1'b1, CTL_NOP,      1'b0, 1'b0, 3'd1, E_FETCH);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sm83_mcycle_seq.md
Name: sm83_mcycle_seq

Overview:
Parametrised M-cycle sequencer for the SM83 core; the next-generation control sequencer. Takes the decoded ctl_op and emits per-M-cycle control strobes. Supports multi-cycle ops, 16-bit immediates via Z/W latches, conditional-length ops and memory wait stalls. The final M-cycle of every op overlaps the next opcode fetch.

Parameters:
MAX_MCYCLES, 6, depth of the per-op step table; elaboration error if < 4
IDX_W, $clog2(MAX_MCYCLES), width of the step index
COND_JR_EN, 1, 1 = CTL_JR_CC_E8 supported; 0 = treated as illegal

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-low
ctl_op  in  ctl_op_t  decoded op; valid while mcycle==0
cond_true  in  1  branch condition from flags, sampled at JR step 0
mem_wait  in  1  memory not ready; stalls the sequencer
addr_sel  out  addr_sel_t  address source: NONE/PC/HL
mem_rd  out  1  memory read this M-cycle
mem_wr  out  1  memory write (r8 -> [addr])
inc_pc  out  1  PC increment
fetch_cycle  out  1  opcode fetch into IR
mem_to_r8  out  1  read data -> r8
z_ld  out  1  read data -> Z
w_ld  out  1  read data -> W
pc_ld_wz  out  1  PC <= {W,Z}
pc_add_z  out  1  PC <= PC + sext(Z)
r16_ld_wz  out  1  r16 <= {W,Z}
mcycle  out  IDX_W  current step index
op_done  out  1  final (fetch) step completing this cycle
illegal_op  out  1  one-cycle pulse: unknown op at step 0

Behaviour:
- Sync reset (rst_n low at posedge): mcycle<=0, op_q<=CTL_NOP, jr_taken_q<=0, boot_q<=1. While rst_n low, all outputs are 0 and addr_sel=NONE.
- boot_q=1: step 0 is a forced FETCH regardless of ctl_op. boot_q clears on a non-stalled cycle.
- At mcycle==0, the live ctl_op selects the sequence and is latched into op_q on a non-stalled cycle. Steps >=1 use op_q.
- Step kinds:
  - FETCH: PC, mem_rd, inc_pc, fetch_cycle, op_done
  - IMM_R8: PC, mem_rd, inc_pc, mem_to_r8
  - IMM_Z: PC, mem_rd, inc_pc, z_ld
  - IMM_W: PC, mem_rd, inc_pc, w_ld
  - HL_R8: HL, mem_rd, mem_to_r8
  - R8_HL: HL, mem_wr
  - INT_JP: NONE, pc_ld_wz
  - INT_JR: NONE, pc_add_z
- Sequences (steps 0..n-1):
  - NOP: FETCH
  - LD_R8_D8: IMM_R8, FETCH
  - LD_R8_HL: HL_R8, FETCH
  - LD_HL_R8: R8_HL, FETCH
  - LD_R16_D16: IMM_Z, IMM_W, FETCH with r16_ld_wz also asserted
  - JP_D16: IMM_Z, IMM_W, INT_JP, FETCH
  - JR_CC_E8: IMM_Z (jr_taken_q<=cond_true), then INT_JR and FETCH if taken, else FETCH
- Unknown op (or JR with COND_JR_EN=0): executes as NOP; illegal_op=1 for that step-0 cycle.
- Advance: if !mem_wait, mcycle <= (last step) ? 0 : mcycle+1. Last step is the FETCH step.
- Stall (mem_wait=1):
  - mcycle, op_q and jr_taken_q hold.
  - addr_sel, mem_rd and mem_wr stay as decoded.
  - inc_pc, fetch_cycle, mem_to_r8, z_ld, w_ld, pc_ld_wz, pc_add_z, r16_ld_wz and op_done are forced 0.
  - illegal_op is suppressed until the non-stalled cycle.
- Stall is unbounded. cond_true is sampled only on the non-stalled IMM_Z cycle of JR.
- Strobes are combinational from (mcycle, op, jr_taken_q, mem_wait, boot_q); zero-latency, same cycle.
- mcycle never exceeds MAX_MCYCLES-1. An out-of-range index (unreachable) decodes as FETCH and returns to 0.
- Reset mid-op: the sequence aborts with no further strobes; the next cycle after release is the boot FETCH.

Test Plan:
- Reset release, ctl_op=CTL_JP_D16 -> cycle 1 is FETCH (fetch_cycle=1, inc_pc=1, addr_sel=PC, op_done=1); mcycle=0 after.
- LD_R8_D8, no wait -> mcycle 0,1; cycle 0: mem_to_r8=1, inc_pc=1; cycle 1: fetch_cycle=1; total 2 inc_pc pulses.
- JP_D16 with mem_wait=1 for 3 cycles at step 1 -> mcycle holds at 1, w_ld=0 and inc_pc=0 during the stall; w_ld=1 once on release; pc_ld_wz at step 2; op_done at step 3.
- JR_CC_E8 cond_true=1 -> 3 steps, pc_add_z=1 at step 1; with cond_true=0 -> 2 steps, pc_add_z never asserted.
- LD_R16_D16 then LD_HL_R8 back-to-back -> steps Z, W, FETCH+r16_ld_wz, then R8_HL (addr_sel=HL, mem_wr=1), FETCH; no idle gap.
- Unknown ctl_op encoding -> illegal_op=1 for exactly one cycle, NOP FETCH behaviour; rst_n low at JP step 2 -> no pc_ld_wz, all outputs 0 during reset, boot FETCH after release.
